// File: rtl/mem_wb_ctrl_pkg.sv
// Shared ISA constants and types for the memory / write-back stage.
// No logic of its own; the opcode helpers are pure combinational functions.
// Not applicable: the package carries no flow control.
package mem_wb_ctrl_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 27;
   localparam int OP_W   = OP_HI - OP_LO + 1;
   localparam int ADDR_W = 12;

   localparam logic [OP_W-1:0] OP_LW = 5'b01000;
   localparam logic [OP_W-1:0] OP_SW = 5'b00111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // M/W pipeline register contents
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] alu;
      logic [31:0] mem;
      logic        valid;
   } mw_t;

   function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] insn);
      return insn[OP_HI:OP_LO];
   endfunction

   function automatic logic is_mem_op(input logic [31:0] insn);
      return (opcode_of(insn) == OP_LW) || (opcode_of(insn) == OP_SW);
   endfunction

endpackage

// File: rtl/mem_wb_ctrl_mw_reg.sv
// M/W pipeline register bank with write enable.
// Latency: 1 cycle from d/we to q.
// Backpressure: we=0 holds the current contents; reset wins over we.
module mw_reg
   import mem_wb_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic we,
   input  mw_t  d,
   output mw_t  q
);

   // Load on write enable, clear on reset
   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_wb_ctrl.sv
// Memory stage controller: issues lw/sw to data memory and fills M/W.
// Latency: 1 cycle for non-memory insns, 1+n for memory ops (n WAIT cycles incl. ack).
// Backpressure: stall freezes upstream while an access waits; a timeout aborts and sets mem_err.
module mem_wb_ctrl
   import mem_wb_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       xm_insn,
   input  logic [31:0]       xm_alu,
   input  logic [31:0]       xm_data_b,
   output logic              dmem_req,
   output logic              dmem_wren,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              stall,
   output logic [31:0]       mw_insn,
   output logic [31:0]       mw_alu,
   output logic [31:0]       mw_mem,
   output logic              mw_valid,
   output logic              mem_err
);

   // Last counter value before the access is abandoned
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [31:0]       lat_insn;
   logic [31:0]       lat_alu;
   logic              lat_wren;

   logic              in_wait;
   logic              xm_is_mem;
   logic              xm_is_sw;
   logic              cnt_last;
   logic              mw_we;
   mw_t               mw_d;
   mw_t               mw_q;

   assign in_wait   = (state == ST_WAIT);
   assign xm_is_mem = is_mem_op(xm_insn);
   assign xm_is_sw  = (opcode_of(xm_insn) == OP_SW);
   assign cnt_last  = (cnt == CNT_LAST);

   // Memory port shows the latched request only while waiting and out of reset
   assign dmem_req   = in_wait && !reset;
   assign dmem_wren  = dmem_req && lat_wren;
   assign dmem_addr  = dmem_req ? lat_addr  : '0;
   assign dmem_wdata = dmem_req ? lat_wdata : '0;

   // Stall and M/W next-value selection; ack and timeout release the stall in their own cycle
   always_comb begin
      stall = 1'b0;
      mw_we = 1'b0;
      mw_d  = '0;
      if (!in_wait) begin
         mw_we = 1'b1;
         if (xm_is_mem) begin
            stall = 1'b1;          // bubble into M/W while the access starts
         end else begin
            mw_d.insn  = xm_insn;
            mw_d.alu   = xm_alu;
            mw_d.valid = (xm_insn != '0);
         end
      end else if (dmem_ack) begin
         mw_we      = 1'b1;
         mw_d.insn  = lat_insn;
         mw_d.alu   = lat_alu;
         mw_d.mem   = lat_wren ? '0 : dmem_rdata;
         mw_d.valid = 1'b1;
      end else if (cnt_last) begin
         mw_we      = 1'b1;        // abort: insn recorded but marked invalid
         mw_d.insn  = lat_insn;
         mw_d.alu   = lat_alu;
      end else begin
         stall = 1'b1;
      end
      if (reset) begin
         stall = 1'b0;
      end
   end

   // FSM, wait counter, request latches and sticky error flag
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_insn  <= '0;
         lat_alu   <= '0;
         lat_wren  <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xm_is_mem) begin
                  lat_addr  <= xm_alu[ADDR_W-1:0];
                  lat_wdata <= xm_data_b;
                  lat_insn  <= xm_insn;
                  lat_alu   <= xm_alu;
                  lat_wren  <= xm_is_sw;
                  cnt       <= '0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  state <= ST_IDLE;
               end else if (cnt_last) begin
                  mem_err <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   mw_reg u_mw_reg (
      .clock (clock),
      .reset (reset),
      .we    (mw_we),
      .d     (mw_d),
      .q     (mw_q)
   );

   assign mw_insn  = mw_q.insn;
   assign mw_alu   = mw_q.alu;
   assign mw_mem   = mw_q.mem;
   assign mw_valid = mw_q.valid;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Scoreboard bench for mem_wb_ctrl: stimulus queues expected values per cycle,
// a negedge monitor pops and compares whatever is due in the current cycle.
// TIMEOUT is 4 so the abort path is reached quickly.
module tb_mem_wb_ctrl;

   localparam logic [31:0] ADD1 = 32'h0800_0003;
   localparam logic [31:0] ADD2 = 32'h0800_0009;
   localparam logic [31:0] LW1  = 32'h4000_0011;
   localparam logic [31:0] SW1  = 32'h3800_0022;

   typedef enum int {F_STALL, F_REQ, F_WREN, F_ADDR, F_WDATA,
                     F_INSN, F_ALU, F_MEM, F_VALID, F_ERR} fld_e;

   typedef struct {
      int          cyc;
      string       name;
      fld_e        fld;
      logic [31:0] val;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] xm_insn = '0, xm_alu = '0, xm_data_b = '0, dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic        dmem_req, dmem_wren, stall, mw_valid, mem_err;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_wdata, mw_insn, mw_alu, mw_mem;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];

   mem_wb_ctrl #(.TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .xm_insn(xm_insn), .xm_alu(xm_alu), .xm_data_b(xm_data_b),
      .dmem_req(dmem_req), .dmem_wren(dmem_wren), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .mw_insn(mw_insn), .mw_alu(mw_alu), .mw_mem(mw_mem),
      .mw_valid(mw_valid), .mem_err(mem_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input fld_e f);
      case (f)
         F_STALL: return {31'd0, stall};
         F_REQ:   return {31'd0, dmem_req};
         F_WREN:  return {31'd0, dmem_wren};
         F_ADDR:  return {20'd0, dmem_addr};
         F_WDATA: return dmem_wdata;
         F_INSN:  return mw_insn;
         F_ALU:   return mw_alu;
         F_MEM:   return mw_mem;
         F_VALID: return {31'd0, mw_valid};
         default: return {31'd0, mem_err};
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle, mid-cycle
   always @(negedge clock) begin
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc == cyc) begin
            logic [31:0] a;
            a = actual(sb[i].fld);
            n_checks++;
            if (a === sb[i].val) n_pass++;
            else $display("FAIL %s (cycle %0d): got %h, expected %h",
                          sb[i].name, cyc, a, sb[i].val);
            sb.delete(i);
            i--;
         end
      end
   end

   task automatic drive(input logic rst, input logic [31:0] insn, input logic [31:0] alu,
                        input logic [31:0] db, input logic ack, input logic [31:0] rdata);
      @(posedge clock);
      #1;
      reset = rst; xm_insn = insn; xm_alu = alu; xm_data_b = db;
      dmem_ack = ack; dmem_rdata = rdata;
   endtask

   task automatic ex(input int c, input string n, input fld_e f, input logic [31:0] v);
      exp_t e;
      e.cyc = c; e.name = n; e.fld = f; e.val = v;
      sb.push_back(e);
   endtask

   initial begin
      int r;

      // Reset: outputs gated even with a memory op presented
      drive(1, 0, 0, 0, 0, 0);
      drive(1, LW1, 32'h10, 0, 0, 0);
      r = cyc;
      ex(r, "rst_stall", F_STALL, 0);
      ex(r, "rst_req", F_REQ, 0);
      ex(r, "rst_valid", F_VALID, 0);
      ex(r, "rst_insn", F_INSN, 0);
      ex(r, "rst_err", F_ERR, 0);

      // insn 0 then add: both single cycle, no stall
      drive(0, 32'h0, 32'h7, 0, 0, 0);
      r = cyc;
      ex(r, "nop_stall", F_STALL, 0);
      ex(r + 1, "nop_valid", F_VALID, 0);
      ex(r + 1, "nop_alu", F_ALU, 32'h7);
      drive(0, ADD1, 32'h5, 0, 0, 0);
      r = cyc;
      ex(r, "add_stall", F_STALL, 0);
      ex(r + 1, "add_valid", F_VALID, 1);
      ex(r + 1, "add_alu", F_ALU, 32'h5);
      ex(r + 1, "add_insn", F_INSN, ADD1);
      ex(r + 1, "add_mem", F_MEM, 0);

      // lw, ack on third WAIT cycle
      drive(0, LW1, 32'h10, 32'h99, 0, 0);
      r = cyc;
      ex(r, "lw_entry_stall", F_STALL, 1);
      ex(r, "lw_entry_req", F_REQ, 0);
      ex(r + 1, "lw_bubble_valid", F_VALID, 0);
      ex(r + 1, "lw_bubble_insn", F_INSN, 0);
      drive(0, LW1, 32'h10, 32'h99, 0, 0);
      r = cyc;
      ex(r, "lw_w1_stall", F_STALL, 1);
      ex(r, "lw_w1_req", F_REQ, 1);
      ex(r, "lw_addr", F_ADDR, 32'h010);
      ex(r, "lw_wren", F_WREN, 0);
      drive(0, LW1, 32'h10, 32'h99, 0, 0);
      ex(cyc, "lw_w2_stall", F_STALL, 1);
      drive(0, LW1, 32'h10, 32'h99, 1, 32'hDEAD_BEEF);
      r = cyc;
      ex(r, "lw_ack_stall", F_STALL, 0);
      ex(r, "lw_ack_req", F_REQ, 1);
      ex(r + 1, "lw_mem", F_MEM, 32'hDEAD_BEEF);
      ex(r + 1, "lw_valid", F_VALID, 1);
      ex(r + 1, "lw_insn", F_INSN, LW1);
      ex(r + 1, "lw_alu", F_ALU, 32'h10);

      // sw, ack in first WAIT cycle; rdata must not leak into mw_mem
      drive(0, SW1, 32'hFF, 32'h1234_5678, 0, 0);
      r = cyc;
      ex(r, "sw_entry_stall", F_STALL, 1);
      ex(r, "sw_entry_wren", F_WREN, 0);
      ex(r, "sw_entry_wdata", F_WDATA, 0);
      drive(0, SW1, 32'hFF, 32'h1234_5678, 1, 32'hAAAA_5555);
      r = cyc;
      ex(r, "sw_wren", F_WREN, 1);
      ex(r, "sw_wdata", F_WDATA, 32'h1234_5678);
      ex(r, "sw_addr", F_ADDR, 32'h0FF);
      ex(r, "sw_ack_stall", F_STALL, 0);

      // add with a stray ack in IDLE: ignored
      drive(0, ADD2, 32'h9, 0, 1, 32'hFFFF_FFFF);
      r = cyc;
      ex(r, "sw_after_wren", F_WREN, 0);
      ex(r, "sw_after_wdata", F_WDATA, 0);
      ex(r, "idle_ack_req", F_REQ, 0);
      ex(r, "idle_ack_stall", F_STALL, 0);
      ex(r, "sw_valid", F_VALID, 1);
      ex(r, "sw_mem", F_MEM, 0);
      ex(r, "sw_insn", F_INSN, SW1);
      ex(r + 1, "idle_ack_mem", F_MEM, 0);
      ex(r + 1, "idle_ack_alu", F_ALU, 32'h9);
      ex(r + 1, "idle_ack_valid", F_VALID, 1);

      // lw with ack exactly in the timeout cycle: ack wins
      drive(0, LW1, 32'h44, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, LW1, 32'h44, 0, 0, 0);
      drive(0, LW1, 32'h44, 0, 1, 32'hCAFE_F00D);
      r = cyc;
      ex(r, "race_stall", F_STALL, 0);
      ex(r + 1, "race_valid", F_VALID, 1);
      ex(r + 1, "race_mem", F_MEM, 32'hCAFE_F00D);
      ex(r + 1, "race_err", F_ERR, 0);

      // lw with no ack: abort after 4 WAIT cycles
      drive(0, LW1, 32'h123, 0, 0, 0);
      r = cyc;
      ex(r, "tmo_entry_stall", F_STALL, 1);
      for (int i = 1; i <= 4; i++) begin
         drive(0, LW1, 32'h123, 0, 0, 0);
         ex(cyc, $sformatf("tmo_w%0d_req", i), F_REQ, 1);
         ex(cyc, $sformatf("tmo_w%0d_stall", i), F_STALL, (i == 4) ? 32'd0 : 32'd1);
      end
      ex(cyc, "tmo_err_before", F_ERR, 0);
      for (int i = 0; i < 10; i++) begin
         drive(0, 32'h1000_0000 + i, 32'h20 + i, 0, 0, 0);
         if (i == 0) begin
            ex(cyc, "tmo_err", F_ERR, 1);
            ex(cyc, "tmo_valid", F_VALID, 0);
            ex(cyc, "tmo_insn", F_INSN, LW1);
            ex(cyc, "tmo_mem", F_MEM, 0);
            ex(cyc, "tmo_after_req", F_REQ, 0);
         end
      end
      ex(cyc + 1, "err_sticky", F_ERR, 1);
      ex(cyc + 1, "err_sticky_valid", F_VALID, 1);

      // lw interrupted by reset in WAIT, then a late ack
      drive(0, LW1, 32'h55, 0, 0, 0);
      drive(0, LW1, 32'h55, 0, 0, 0);
      ex(cyc, "rw_w1_req", F_REQ, 1);
      drive(1, LW1, 32'h55, 0, 0, 0);
      r = cyc;
      ex(r, "rw_rst_req", F_REQ, 0);
      ex(r, "rw_rst_stall", F_STALL, 0);
      drive(0, 32'h0, 32'h0, 0, 1, 32'h1111_1111);
      r = cyc;
      ex(r, "rw_req", F_REQ, 0);
      ex(r, "rw_stall", F_STALL, 0);
      ex(r, "rw_insn", F_INSN, 0);
      ex(r, "rw_alu", F_ALU, 0);
      ex(r, "rw_mem", F_MEM, 0);
      ex(r, "rw_valid", F_VALID, 0);
      ex(r, "rw_err", F_ERR, 0);
      ex(r + 1, "rw_late_mem", F_MEM, 0);
      ex(r + 1, "rw_late_valid", F_VALID, 0);
      ex(r + 1, "rw_late_err", F_ERR, 0);
      ex(r + 1, "rw_late_req", F_REQ, 0);

      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);

      @(negedge clock);
      n_checks++;
      if (dmem_req === 1'b0) n_pass++;
      else $display("FAIL end_req: got %b, expected 0", dmem_req);
      n_checks++;
      if (stall === 1'b0) n_pass++;
      else $display("FAIL end_stall: got %b, expected 0", stall);
      n_checks++;
      if (mw_valid === 1'b0) n_pass++;
      else $display("FAIL end_valid: got %b, expected 0", mw_valid);
      n_checks++;
      if (mem_err === 1'b0) n_pass++;
      else $display("FAIL end_err: got %b, expected 0", mem_err);
      n_checks++;
      if (mw_insn === 32'h0) n_pass++;
      else $display("FAIL end_insn: got %h, expected 0", mw_insn);
      n_checks++;
      if (mw_alu === 32'h0) n_pass++;
      else $display("FAIL end_alu: got %h, expected 0", mw_alu);

      foreach (sb[i]) begin
         n_checks++;
         $display("FAIL %s: expectation for cycle %0d never compared", sb[i].name, sb[i].cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
